nms_sequencer: RTL and testbench
================================

NMS_SEQUENCER -- requirements
Module: nms_sequencer

Interface
REQ-001 The block SHALL have parameter IMG_W, default 16, meaning pixels per row (legal range 3..1024).
REQ-002 The block SHALL have parameter IMG_H, default 16, meaning rows per frame (legal range 3..1024).
REQ-003 clk  input  1  the single clock; all state updates on the rising edge.
REQ-004 rst  input  1  reset, synchronous, active-high.
REQ-005 start  input  1  one-cycle pulse that begins a frame; honoured only in IDLE.
REQ-006 in_valid  input  1  a raster-order pixel is offered.
REQ-007 in_mag  input  8  gradient magnitude of the offered pixel.
REQ-008 in_angle  input  2  quantised gradient direction of the offered pixel.
REQ-009 in_ready  output  1  the block accepts the offered pixel this cycle.
REQ-010 out_valid  output  1  the window outputs hold a valid interior window.
REQ-011 out_ready  input  1  the downstream NMS stage consumes the window this cycle.
REQ-012 win_mag  output  9x8  3x3 magnitude window, row-major, index 0 top-left, 4 centre, 8 bottom-right.
REQ-013 win_angle  output  2  angle of the centre pixel.
REQ-014 out_row, out_col  output  10 each  frame coordinates of the centre pixel.
REQ-015 frame_done  output  1  one-cycle pulse after the last window of a frame is consumed.

Function
REQ-016 The FSM SHALL have states IDLE, ACTIVE, DRAIN and DONE.
- IDLE->ACTIVE on start.
- ACTIVE->DRAIN when pixel (IMG_H-1, IMG_W-1) is accepted.
- DRAIN->DONE when out_valid && out_ready.
- DONE->IDLE unconditionally after one cycle.
REQ-017 Input handshake:
- in_ready = (state==ACTIVE) && (!out_valid || out_ready).
- A pixel is accepted when in_valid && in_ready.
- in_ready SHALL be 0 in IDLE, DRAIN and DONE.
REQ-018 Counters:
- col increments on each accepted pixel and wraps IMG_W-1->0.
- row increments on that wrap.
- Both counters clear on start.
REQ-019 Line buffers: the block SHALL keep two line buffers of IMG_W entries x 10 bits (mag+angle) holding rows r-1 and r-2, plus 3x3 shift registers fed from them on each accept.
REQ-020 Window validity: accepting pixel (r,c) with r>=2 and c>=2 SHALL produce a window centred on (r-1,c-1), so win_mag[6..8] = row r, columns c-2..c.
- Pixels with r<2 or c<2 SHALL produce no output.
- Exactly (IMG_W-2)*(IMG_H-2) windows SHALL be produced per frame.
REQ-021 Latency: out_valid, win_mag, win_angle, out_row and out_col SHALL be registered and update on the clock edge that accepts the completing pixel, i.e. valid in the next cycle.
REQ-022 Output hold: while out_valid && !out_ready, all window outputs SHALL hold stable and no new pixel SHALL be accepted.
REQ-023 Simultaneous events: out_ready together with the accept of a new window-completing pixel SHALL replace the window in the same edge with out_valid staying 1; out_valid falls only when it is consumed with no replacement.
REQ-024 start SHALL be ignored outside IDLE.
REQ-025 in_valid SHALL be ignored while in_ready is 0.
REQ-026 Row wrap: window columns SHALL never mix pixels from different rows.
REQ-027 frame_done SHALL be 1 only in DONE.

Reset
REQ-028 rst SHALL force the following on the next edge, from any state including mid-frame:
- state=IDLE.
- row=col=0.
- out_valid=0, in_ready=0, frame_done=0.
- win_mag=0, win_angle=0, out_row=0, out_col=0.
REQ-029 Line-buffer and shift-register contents are not reset; no output SHALL depend on them before being rewritten in the new frame.

Verification
REQ-030 IMG_W=IMG_H=4, start, 16 pixels with mag=index 0..15, out_ready=1 -> 4 windows:
- centre (1,1): win_mag=0,1,2,4,5,6,8,9,10.
- Centres (1,2), (2,1) and (2,2) follow in that order.
- frame_done pulses once, 1 cycle after the last window is consumed.
REQ-031 Same frame with out_ready=0 for 5 cycles after the first window -> window (1,1) held unchanged, in_ready=0 throughout, no pixel lost, 4 windows total.
REQ-032 in_valid toggled 1/0 each cycle, IMG_W=5, IMG_H=3 -> exactly 3 windows; centres (1,1), (1,2), (1,3); no window spans the row wrap.
REQ-033 rst asserted after pixel 9 of a 4x4 frame, then start with a fresh frame -> outputs zero the cycle after rst; the second frame produces exactly the 4 REQ-030 windows, with no stale data.
REQ-034 start pulsed in ACTIVE and DRAIN, and in_valid driven in IDLE -> both ignored; counters and window count unaffected.

Source files
------------

// File: rtl/nms_sequencer.sv
// Raster-scan 3x3 window sequencer feeding a non-maximum-suppression stage.
// Two line buffers plus a 3x3 shift register build each interior window from the pixel stream.
module nms_sequencer #(
    parameter int IMG_W = 16,
    parameter int IMG_H = 16
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            start,
    input  logic            in_valid,
    input  logic [7:0]      in_mag,
    input  logic [1:0]      in_angle,
    output logic            in_ready,
    output logic            out_valid,
    input  logic            out_ready,
    output logic [8:0][7:0] win_mag,
    output logic [1:0]      win_angle,
    output logic [9:0]      out_row,
    output logic [9:0]      out_col,
    output logic            frame_done
);

    localparam int         CW       = $clog2(IMG_W);
    localparam logic [9:0] COL_LAST = 10'(IMG_W - 1);
    localparam logic [9:0] ROW_LAST = 10'(IMG_H - 1);

    typedef enum logic [1:0] {
        IDLE,
        ACTIVE,
        DRAIN,
        DONE
    } state_t;

    state_t          state_q, state_d;
    logic [9:0]      row_q, row_d;
    logic [9:0]      col_q, col_d;
    logic            out_valid_q, out_valid_d;
    logic [8:0][7:0] win_mag_q, win_mag_d;
    logic [1:0]      win_angle_q, win_angle_d;
    logic [9:0]      out_row_q, out_row_d;
    logic [9:0]      out_col_q, out_col_d;

    // Each entry packs {mag, angle}; lb1 holds row r-1, lb2 holds row r-2.
    logic [9:0]      lb1_q [IMG_W];
    logic [9:0]      lb1_d [IMG_W];
    logic [9:0]      lb2_q [IMG_W];
    logic [9:0]      lb2_d [IMG_W];
    logic [9:0]      sr_q  [9];
    logic [9:0]      sr_d  [9];

    logic            accept;
    logic            completes;
    logic [CW-1:0]   col_idx;
    logic [9:0]      pix;

    assign col_idx = col_q[CW-1:0];
    assign pix     = {in_mag, in_angle};

    always_comb begin
        state_d     = state_q;
        row_d       = row_q;
        col_d       = col_q;
        out_valid_d = out_valid_q;
        win_mag_d   = win_mag_q;
        win_angle_d = win_angle_q;
        out_row_d   = out_row_q;
        out_col_d   = out_col_q;
        lb1_d       = lb1_q;
        lb2_d       = lb2_q;
        sr_d        = sr_q;

        in_ready  = (state_q == ACTIVE) && (!out_valid_q || out_ready);
        accept    = in_valid && in_ready;
        completes = accept && (row_q >= 10'd2) && (col_q >= 10'd2);

        case (state_q)
            IDLE: begin
                if (start) begin
                    state_d = ACTIVE;
                    row_d   = '0;
                    col_d   = '0;
                end
            end
            ACTIVE: begin
                if (accept) begin
                    if (col_q == COL_LAST) begin
                        col_d = '0;
                        row_d = row_q + 10'd1;
                    end else begin
                        col_d = col_q + 10'd1;
                    end
                    if ((row_q == ROW_LAST) && (col_q == COL_LAST)) begin
                        state_d = DRAIN;
                    end
                end
            end
            DRAIN: begin
                if (out_valid_q && out_ready) begin
                    state_d = DONE;
                end
            end
            DONE: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase

        // Window shifts one column left; the new right column comes from the buffers and the input.
        if (accept) begin
            sr_d[0] = sr_q[1];
            sr_d[1] = sr_q[2];
            sr_d[2] = lb2_q[col_idx];
            sr_d[3] = sr_q[4];
            sr_d[4] = sr_q[5];
            sr_d[5] = lb1_q[col_idx];
            sr_d[6] = sr_q[7];
            sr_d[7] = sr_q[8];
            sr_d[8] = pix;
            lb2_d[col_idx] = lb1_q[col_idx];
            lb1_d[col_idx] = pix;
        end

        // A completing accept reloads the outputs even if the old window is consumed on the same edge.
        if (completes) begin
            out_valid_d  = 1'b1;
            win_mag_d[0] = sr_d[0][9:2];
            win_mag_d[1] = sr_d[1][9:2];
            win_mag_d[2] = sr_d[2][9:2];
            win_mag_d[3] = sr_d[3][9:2];
            win_mag_d[4] = sr_d[4][9:2];
            win_mag_d[5] = sr_d[5][9:2];
            win_mag_d[6] = sr_d[6][9:2];
            win_mag_d[7] = sr_d[7][9:2];
            win_mag_d[8] = sr_d[8][9:2];
            win_angle_d  = sr_d[4][1:0];
            out_row_d    = row_q - 10'd1;
            out_col_d    = col_q - 10'd1;
        end else if (out_valid_q && out_ready) begin
            out_valid_d = 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= IDLE;
            row_q       <= '0;
            col_q       <= '0;
            out_valid_q <= 1'b0;
            win_mag_q   <= '0;
            win_angle_q <= '0;
            out_row_q   <= '0;
            out_col_q   <= '0;
        end else begin
            state_q     <= state_d;
            row_q       <= row_d;
            col_q       <= col_d;
            out_valid_q <= out_valid_d;
            win_mag_q   <= win_mag_d;
            win_angle_q <= win_angle_d;
            out_row_q   <= out_row_d;
            out_col_q   <= out_col_d;
        end
    end

    // Storage is always overwritten before it can reach an output, so it carries no reset.
    always_ff @(posedge clk) begin
        lb1_q <= lb1_d;
        lb2_q <= lb2_d;
        sr_q  <= sr_d;
    end

    assign out_valid  = out_valid_q;
    assign win_mag    = win_mag_q;
    assign win_angle  = win_angle_q;
    assign out_row    = out_row_q;
    assign out_col    = out_col_q;
    assign frame_done = (state_q == DONE);

endmodule

// File: tb/tb_nms_sequencer.sv
// Scoreboard bench for nms_sequencer: expected windows are computed per frame from the
// whole pixel array and consumed by an independent monitor whenever the DUT hands one over.
module tb_nms_sequencer;

    localparam int W = 4;
    localparam int H = 4;

    logic            clk = 1'b0;
    logic            rst = 1'b1;
    logic            start = 1'b0;
    logic            in_valid = 1'b0;
    logic [7:0]      in_mag = '0;
    logic [1:0]      in_angle = '0;
    logic            out_ready = 1'b0;
    logic            in_ready;
    logic            out_valid;
    logic [8:0][7:0] win_mag;
    logic [1:0]      win_angle;
    logic [9:0]      out_row;
    logic [9:0]      out_col;
    logic            frame_done;

    always #5 clk = ~clk;

    nms_sequencer #(.IMG_W(W), .IMG_H(H)) dut (
        .clk       (clk),
        .rst       (rst),
        .start     (start),
        .in_valid  (in_valid),
        .in_mag    (in_mag),
        .in_angle  (in_angle),
        .in_ready  (in_ready),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .win_mag   (win_mag),
        .win_angle (win_angle),
        .out_row   (out_row),
        .out_col   (out_col),
        .frame_done(frame_done)
    );

    typedef struct {
        logic [8:0][7:0] mag;
        logic [1:0]      ang;
        logic [9:0]      row;
        logic [9:0]      col;
    } win_t;

    win_t       exp_q[$];
    win_t       held;
    logic [7:0] fmag [H][W];
    logic [1:0] fang [H][W];

    int errors = 0;
    int checks = 0;
    int done_cnt = 0;
    bit hold_pending = 0;
    bit done_exp = 0;
    int ready_mode = 0;
    bit stall_armed = 0;
    int stall_left = 0;

    // Downstream readiness: 0 always ready, 1 random, 2 single 5-cycle stall on first window.
    initial begin
        forever begin
            @(posedge clk);
            #1;
            case (ready_mode)
                0: out_ready = 1'b1;
                1: out_ready = ($urandom_range(0, 3) != 0);
                default: begin
                    if (stall_left > 0) begin
                        out_ready = 1'b0;
                        stall_left--;
                    end else if (stall_armed && out_valid) begin
                        stall_armed = 0;
                        stall_left = 4;
                        out_ready = 1'b0;
                    end else begin
                        out_ready = 1'b1;
                    end
                end
            endcase
        end
    end

    always @(negedge clk) begin
        if (rst) begin
            hold_pending = 0;
            done_exp = 0;
        end else begin
            if (done_exp || frame_done) begin
                checks++;
                if (frame_done !== done_exp) begin
                    errors++;
                    $display("FAIL frame_done: got %0b expected %0b", frame_done, done_exp);
                end
            end
            if (frame_done) done_cnt++;
            done_exp = 0;

            if (hold_pending) begin
                checks++;
                if (out_valid !== 1'b1 || win_mag !== held.mag || win_angle !== held.ang ||
                    out_row !== held.row || out_col !== held.col) begin
                    errors++;
                    $display("FAIL hold: got v=%0b mag=%h rc=%0d,%0d expected v=1 mag=%h rc=%0d,%0d",
                             out_valid, win_mag, out_row, out_col, held.mag, held.row, held.col);
                end
            end
            hold_pending = 0;

            if (out_valid && !out_ready) begin
                checks++;
                if (in_ready !== 1'b0) begin
                    errors++;
                    $display("FAIL stall_in_ready: got %0b expected 0", in_ready);
                end
                held.mag = win_mag;
                held.ang = win_angle;
                held.row = out_row;
                held.col = out_col;
                hold_pending = 1;
            end

            if (out_valid && out_ready) begin
                checks++;
                if (exp_q.size() == 0) begin
                    errors++;
                    $display("FAIL extra_window: got window rc=%0d,%0d expected none", out_row, out_col);
                end else begin
                    win_t w;
                    w = exp_q.pop_front();
                    if (win_mag !== w.mag || win_angle !== w.ang || out_row !== w.row || out_col !== w.col) begin
                        errors++;
                        $display("FAIL window: got mag=%h ang=%0d rc=%0d,%0d expected mag=%h ang=%0d rc=%0d,%0d",
                                 win_mag, win_angle, out_row, out_col, w.mag, w.ang, w.row, w.col);
                    end
                    if (exp_q.size() == 0) done_exp = 1;
                end
            end
        end
    end

    task automatic fill_frame(input bit idx_pattern);
        for (int r = 0; r < H; r++) begin
            for (int c = 0; c < W; c++) begin
                fmag[r][c] = idx_pattern ? 8'(r * W + c) : 8'($urandom);
                fang[r][c] = idx_pattern ? 2'(r * W + c) : 2'($urandom);
            end
        end
    endtask

    // Every interior pixel is the centre of one window, produced in raster order of centres.
    task automatic push_expect();
        for (int r = 1; r < H - 1; r++) begin
            for (int c = 1; c < W - 1; c++) begin
                win_t w;
                for (int k = 0; k < 9; k++) w.mag[k] = fmag[r - 1 + k / 3][c - 1 + k % 3];
                w.ang = fang[r][c];
                w.row = 10'(r);
                w.col = 10'(c);
                exp_q.push_back(w);
            end
        end
    endtask

    // vmode: 0 always valid, 1 alternate cycles, 2 random. stop_after < 0 feeds the whole frame.
    task automatic feed_frame(input int vmode, input bit poke_start, input int stop_after);
        int idx = 0;
        int guard = 0;
        bit accepted;
        start = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0;
        while (idx < W * H && idx != stop_after && guard < 2000) begin
            case (vmode)
                0: in_valid = 1'b1;
                1: in_valid = (guard % 2 == 0);
                default: in_valid = 1'($urandom_range(0, 1));
            endcase
            if (in_valid) begin
                in_mag = fmag[idx / W][idx % W];
                in_angle = fang[idx / W][idx % W];
            end else begin
                in_mag = 8'($urandom);
                in_angle = 2'($urandom);
            end
            start = poke_start && (idx == 5);
            @(negedge clk);
            accepted = in_valid && in_ready;
            @(posedge clk);
            #1;
            if (accepted) idx++;
            guard++;
        end
        in_valid = 1'b0;
        start = 1'b0;
        if (guard >= 2000) begin
            checks++;
            errors++;
            $display("FAIL feed_timeout: got %0d pixels accepted expected %0d", idx, W * H);
        end
        if (poke_start && idx == W * H) begin
            start = 1'b1;
            @(posedge clk);
            #1;
            start = 1'b0;
        end
    endtask

    task automatic wait_done();
        int d0 = done_cnt;
        int n = 0;
        while (done_cnt == d0 && n < 200) begin
            @(posedge clk);
            n++;
        end
        checks++;
        if (done_cnt == d0) begin
            errors++;
            $display("FAIL done_timeout: got no frame_done expected one within 200 cycles");
        end
        @(posedge clk);
        #1;
        checks++;
        if (exp_q.size() != 0) begin
            errors++;
            $display("FAIL window_count: got %0d windows missing expected 0", exp_q.size());
        end
    endtask

    task automatic do_reset();
        rst = 1'b1;
        in_valid = 1'b0;
        start = 1'b0;
        exp_q.delete();
        @(posedge clk);
        #1;
        checks++;
        if (out_valid !== 1'b0 || in_ready !== 1'b0 || frame_done !== 1'b0 || win_mag !== '0 ||
            win_angle !== 2'd0 || out_row !== 10'd0 || out_col !== 10'd0) begin
            errors++;
            $display("FAIL reset_state: got v=%0b rdy=%0b done=%0b mag=%h ang=%0d rc=%0d,%0d expected all zero",
                     out_valid, in_ready, frame_done, win_mag, win_angle, out_row, out_col);
        end
        rst = 1'b0;
    endtask

    task automatic idle_junk(input int n);
        for (int i = 0; i < n; i++) begin
            in_valid = 1'b1;
            in_mag = 8'($urandom);
            in_angle = 2'($urandom);
            @(negedge clk);
            checks++;
            if (in_ready !== 1'b0 || out_valid !== 1'b0) begin
                errors++;
                $display("FAIL idle_ignore: got rdy=%0b v=%0b expected 0 0", in_ready, out_valid);
            end
            @(posedge clk);
            #1;
        end
        in_valid = 1'b0;
    endtask

    initial begin
        do_reset();
        idle_junk(6);

        ready_mode = 0;
        fill_frame(1);
        push_expect();
        feed_frame(0, 0, -1);
        wait_done();

        ready_mode = 2;
        stall_armed = 1;
        fill_frame(1);
        push_expect();
        feed_frame(0, 0, -1);
        wait_done();

        ready_mode = 0;
        fill_frame(0);
        push_expect();
        feed_frame(1, 1, -1);
        wait_done();

        fill_frame(1);
        push_expect();
        feed_frame(0, 0, 12);
        do_reset();
        fill_frame(1);
        push_expect();
        feed_frame(0, 0, 10);
        do_reset();
        fill_frame(1);
        push_expect();
        feed_frame(0, 0, -1);
        wait_done();

        ready_mode = 1;
        for (int f = 0; f < 6; f++) begin
            fill_frame(0);
            push_expect();
            feed_frame(2, f % 2 == 1, -1);
            wait_done();
        end

        ready_mode = 0;
        idle_junk(4);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
